rng_word_fifo: RTL and testbench

- Downstream consumer of the chaotic scroll generator.
- Each cycle it samples the generator's x/y/z state and folds the three 32-bit words into one whitened 32-bit word.
- A programmable decimation counter thins the stream. Kept words are buffered in a small first-word-fall-through FIFO.
- The FIFO is drained by the wishbone register front-end. It exposes fill level, overflow and a level-threshold interrupt.

---
 rtl/rng_word_fifo.sv | 147 ++++++++++++++
 tb/tb_rng_word_fifo.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_word_fifo.sv
// ============================================================================
// Module   : rng_word_fifo
// Purpose  : Whitens generator x/y/z state into 32-bit words, decimates the
//            stream and buffers kept words in a first-word-fall-through FIFO.
//            Optional repetition health test: define RNG_WORD_HEALTH_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rng_word_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [31:0]   x,
    input  logic [31:0]   y,
    input  logic [31:0]   z,
    input  logic [7:0]    decim,
    input  logic [AW:0]   thresh,
    input  logic          rd_en,
    output logic [31:0]   rd_data,
    output logic          rd_valid,
    output logic [AW:0]   level,
    output logic          full,
    output logic          ovf,
    output logic          irq,
    output logic          hfail
);

    localparam logic [AW:0] c_full_level = (AW+1)'(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr_q, w_wptr_d;
    logic [AW-1:0] r_rptr_q, w_rptr_d;
    logic [AW:0]   r_level_q, w_level_d;
    logic [7:0]    r_cnt_q, w_cnt_d;
    logic          r_ovf_q, w_ovf_d;

    logic [31:0]   w_word;
    logic          w_cand;
    logic          w_push_req;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;

    assign w_word = x ^ {y[15:0], y[31:16]} ^ {z[7:0], z[31:8]};

    // Using >= lets the counter recover if decim is lowered mid-run.
    always_comb begin
        w_cand  = en && (r_cnt_q >= decim) && !clr;
        w_cnt_d = r_cnt_q;
        if (clr) begin
            w_cnt_d = 8'd0;
        end else if (en) begin
            w_cnt_d = (r_cnt_q >= decim) ? 8'd0 : r_cnt_q + 8'd1;
        end
    end

`ifdef RNG_WORD_HEALTH_EN
    logic [31:0] r_last_q, w_last_d;
    logic        r_hfail_q, w_hfail_d;
    logic        w_repeat;

    always_comb begin
        w_repeat   = (w_word == r_last_q);
        w_push_req = w_cand && !w_repeat;
        w_last_d   = w_cand ? w_word : r_last_q;
        w_hfail_d  = clr ? 1'b0 : (r_hfail_q | (w_cand && w_repeat));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_q  <= 32'd0;
            r_hfail_q <= 1'b0;
        end else begin
            r_last_q  <= w_last_d;
            r_hfail_q <= w_hfail_d;
        end
    end

    assign hfail = r_hfail_q;
`else
    assign w_push_req = w_cand;
    assign hfail      = 1'b0;
`endif

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    always_comb begin
        w_empty = (r_level_q == '0);
        w_full  = (r_level_q == c_full_level);
        w_pop   = rd_en && !w_empty && !clr;
        w_push  = w_push_req && (!w_full || w_pop);
    end

    always_comb begin
        w_wptr_d  = r_wptr_q;
        w_rptr_d  = r_rptr_q;
        w_level_d = r_level_q;
        w_ovf_d   = r_ovf_q;
        if (clr) begin
            w_wptr_d  = '0;
            w_rptr_d  = '0;
            w_level_d = '0;
            w_ovf_d   = 1'b0;
        end else begin
            if (w_push) w_wptr_d = r_wptr_q + AW'(1);
            if (w_pop)  w_rptr_d = r_rptr_q + AW'(1);
            if (w_push && !w_pop)      w_level_d = r_level_q + (AW+1)'(1);
            else if (w_pop && !w_push) w_level_d = r_level_q - (AW+1)'(1);
            if (w_push_req && w_full && !w_pop) w_ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr_q  <= '0;
            r_rptr_q  <= '0;
            r_level_q <= '0;
            r_cnt_q   <= 8'd0;
            r_ovf_q   <= 1'b0;
        end else begin
            r_wptr_q  <= w_wptr_d;
            r_rptr_q  <= w_rptr_d;
            r_level_q <= w_level_d;
            r_cnt_q   <= w_cnt_d;
            r_ovf_q   <= w_ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr_q] <= w_word;
    end

    assign rd_valid = !w_empty;
    assign rd_data  = w_empty ? 32'd0 : r_mem[r_rptr_q];
    assign level    = r_level_q;
    assign full     = w_full;
    assign ovf      = r_ovf_q;
    assign irq      = (thresh != '0) && (r_level_q >= thresh);

endmodule

`default_nettype wire

// File: tb/tb_rng_word_fifo.sv
// ============================================================================
// Module   : tb_rng_word_fifo
// Purpose  : Self-checking bench for rng_word_fifo: queue-based reference
//            model compared every cycle, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rng_word_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          en = 1'b0;
    logic [31:0]   x = 32'd0;
    logic [31:0]   y = 32'd0;
    logic [31:0]   z = 32'd0;
    logic [7:0]    decim = 8'd0;
    logic [AW:0]   thresh = '0;
    logic          rd_en = 1'b0;
    logic [31:0]   rd_data;
    logic          rd_valid;
    logic [AW:0]   level;
    logic          full;
    logic          ovf;
    logic          irq;
    logic          hfail;

    int total = 0;
    int bad   = 0;

    rng_word_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en),
        .x(x), .y(y), .z(z), .decim(decim), .thresh(thresh),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .level(level), .full(full), .ovf(ovf), .irq(irq), .hfail(hfail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] whiten(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
        logic [31:0] rb, rc;
        rb = (b << 16) | (b >> 16);
        rc = (c >> 8) | (c << 24);
        return a ^ rb ^ rc;
    endfunction

    // Reference model
    logic [31:0] mq[$];
    int          mcnt   = 0;
    bit          movf   = 1'b0;
    bit          mhfail = 1'b0;
    logic [31:0] mlast  = 32'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mcnt   = 0;
            movf   = 1'b0;
            mhfail = 1'b0;
            mlast  = 32'd0;
        end else if (clr) begin
            mq.delete();
            mcnt   = 0;
            movf   = 1'b0;
            mhfail = 1'b0;
        end else begin
            bit          cand;
            logic [31:0] w;
            cand = 1'b0;
            w    = whiten(x, y, z);
            if (en) begin
                if (mcnt >= int'(decim)) begin
                    cand = 1'b1;
                    mcnt = 0;
                end else begin
                    mcnt++;
                end
            end
`ifdef RNG_WORD_HEALTH_EN
            if (cand) begin
                if (w == mlast) begin
                    mhfail = 1'b1;
                    mlast  = w;
                    cand   = 1'b0;
                end else begin
                    mlast = w;
                end
            end
`endif
            if (rd_en && mq.size() > 0) void'(mq.pop_front());
            if (cand) begin
                if (mq.size() < DEPTH) mq.push_back(w);
                else                   movf = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("cyc_rd_valid", {31'd0, rd_valid}, {31'd0, mq.size() > 0});
            chk("cyc_rd_data", rd_data, (mq.size() > 0) ? mq[0] : 32'd0);
            chk("cyc_level", {28'd0, level}, mq.size());
            chk("cyc_full", {31'd0, full}, {31'd0, mq.size() == DEPTH});
            chk("cyc_ovf", {31'd0, ovf}, {31'd0, movf});
            chk("cyc_irq", {31'd0, irq},
                {31'd0, (thresh != 0) && (mq.size() >= int'(thresh))});
            chk("cyc_hfail", {31'd0, hfail}, {31'd0, mhfail});
        end
    end

    task automatic cyc(input bit e, input logic [31:0] xv, input bit r);
        en    = e;
        x     = xv;
        rd_en = r;
        @(negedge clk);
    endtask

    task automatic clear_cycle();
        en    = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b1;
        @(negedge clk);
        clr   = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_level", {28'd0, level}, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_hfail", {31'd0, hfail}, 32'd0);
        rst_n = 1'b1;

        // Whitening of rotated operands
        decim = 8'd0;
        y = 32'h0001_0000;
        z = 32'h0000_0100;
        cyc(1'b1, 32'h0000_0001, 1'b0);
        chk("wh_rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("wh_rd_data", rd_data, 32'h0000_0001);
        chk("wh_level", {28'd0, level}, 32'd1);
        chk("wh_irq_thresh0", {31'd0, irq}, 32'd0);
        y = 32'd0;
        z = 32'd0;
        cyc(1'b0, 32'd0, 1'b1);
        chk("pop_level", {28'd0, level}, 32'd0);
        cyc(1'b0, 32'd0, 1'b1);
        chk("underflow_level", {28'd0, level}, 32'd0);

        // Decimation by 4
        clear_cycle();
        decim = 8'd3;
        for (int i = 1; i <= 12; i++) cyc(1'b1, 32'(i), 1'b0);
        chk("dec_level", {28'd0, level}, 32'd3);
        for (int k = 1; k <= 3; k++) begin
            chk("dec_word", rd_data, 32'(4 * k));
            cyc(1'b0, 32'd0, 1'b1);
        end

        // Overflow
        clear_cycle();
        decim = 8'd0;
        for (int i = 1; i <= 10; i++) cyc(1'b1, 32'(100 + i), 1'b0);
        chk("ovf_full", {31'd0, full}, 32'd1);
        chk("ovf_level", {28'd0, level}, 32'd8);
        chk("ovf_flag", {31'd0, ovf}, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            chk("ovf_word", rd_data, 32'(100 + i));
            cyc(1'b0, 32'd0, 1'b1);
        end
        chk("ovf_sticky", {31'd0, ovf}, 32'd1);
        chk("ovf_drained", {28'd0, level}, 32'd0);
        clear_cycle();
        chk("ovf_clr", {31'd0, ovf}, 32'd0);

        // Push and pop together while full
        for (int i = 1; i <= 8; i++) cyc(1'b1, 32'(200 + i), 1'b0);
        cyc(1'b1, 32'd209, 1'b1);
        chk("pp_level", {28'd0, level}, 32'd8);
        chk("pp_ovf", {31'd0, ovf}, 32'd0);
        chk("pp_full", {31'd0, full}, 32'd1);
        for (int i = 2; i <= 9; i++) begin
            chk("pp_word", rd_data, 32'(200 + i));
            cyc(1'b0, 32'd0, 1'b1);
        end

        // Threshold interrupt and asynchronous reset
        thresh = 4'd4;
        for (int i = 1; i <= 4; i++) cyc(1'b1, 32'(300 + i), 1'b0);
        chk("irq_set", {31'd0, irq}, 32'd1);
        cyc(1'b0, 32'd0, 1'b1);
        chk("irq_clear", {31'd0, irq}, 32'd0);
        chk("irq_level", {28'd0, level}, 32'd3);
        cyc(1'b1, 32'd305, 1'b0);
        chk("irq_again", {31'd0, irq}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level", {28'd0, level}, 32'd0);
        chk("arst_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("arst_irq", {31'd0, irq}, 32'd0);
        chk("arst_rd_data", rd_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        decim = 8'd2;
        cyc(1'b1, 32'd401, 1'b0);
        cyc(1'b1, 32'd402, 1'b0);
        chk("post_rst_wait", {28'd0, level}, 32'd0);
        cyc(1'b1, 32'd403, 1'b0);
        chk("post_rst_level", {28'd0, level}, 32'd1);
        chk("post_rst_word", rd_data, 32'd403);

        // Repetition test with constant generator state
        clear_cycle();
        thresh = '0;
        decim  = 8'd0;
        y = 32'h1234_5678;
        z = 32'h0BAD_F00D;
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'hA5A5_0F0F, 1'b0);
`ifdef RNG_WORD_HEALTH_EN
        chk("hlt_level", {28'd0, level}, 32'd1);
        chk("hlt_hfail", {31'd0, hfail}, 32'd1);
`else
        chk("hlt_level", {28'd0, level}, 32'd3);
        chk("hlt_hfail", {31'd0, hfail}, 32'd0);
`endif
        chk("hlt_ovf", {31'd0, ovf}, 32'd0);
        clear_cycle();
        chk("hlt_clr", {31'd0, hfail}, 32'd0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
